// File: rtl/tx_pkt_arbiter_pkg.sv
// Shared types and helpers for the TX packet arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tx_pkt_arbiter_pkg;

    // Packetizer modulation modes. The arbiter itself only ever forwards a
    // per-packet BPSK/QPSK flag; MIX is the packetizer's mixed header mode.
    localparam logic [1:0] MODE_QPSK = 2'd0;
    localparam logic [1:0] MODE_BPSK = 2'd1;
    localparam logic [1:0] MODE_MIX  = 2'd2;

    // Payload length in bits, as carried in the packetizer header.
    typedef logic [15:0] len_t;

    // One-hot scheduler states.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_XFER  = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_GAP   = 5'b10000
    } state_t;

    // One AXIS word carries one symbol: BPSK packs 1 bit per symbol and
    // QPSK 2 bits, so an odd QPSK length drops its trailing bit.
    function automatic len_t len_to_symbols(input len_t len_bits, input logic is_bpsk);
        return is_bpsk ? len_bits : (len_bits >> 1);
    endfunction

endpackage

// File: rtl/tx_pkt_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational winner, priority flips on completion.
// Latency: winner is combinational from req; priority updates one cycle after upd.
// Backpressure: none; the caller decides when to sample the winner.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   req         per-channel request level
//   upd         one-cycle pulse: the channel in upd_gnt completed a packet
//   upd_gnt     one-hot channel that completed
//   win         one-hot winner (0 when nobody requests)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic [1:0] upd_gnt,
    output logic [1:0] win
);

    // Channel favoured when both request: 0 = ch0, 1 = ch1. Starts at ch0.
    logic prio;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (upd) begin
            // The channel that just finished loses the next tie.
            prio <= ~upd_gnt[1];
        end
    end

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Schedules two payload sources (ch0 control, ch1 data) into the TX packetizer input.
// Latency: grant 1 cycle after req sampled in IDLE; first m_tvalid 2 cycles after req.
// Backpressure: m_tready passes straight to the granted source; XFER stalls without limit.
//
// Ports:
//   clk, rst_n           slow symbol clock, synchronous active-low reset
//   enable               allows new grants; a packet in flight always completes
//   req/req_len*/req_bpsk per-channel request level, bit length and modulation
//   s0_*, s1_*           payload source AXIS (one word = one symbol)
//   m_*                  packetizer input AXIS; m_tuser = is_bpsk
//   payload_length       bit length latched at grant, held until the next grant
//   pkt_sent             packetizer level; its rising edge marks packet completion
//   grant/done/err/busy  one-hot owner, completion pulse, error pulse, not-idle
module tx_pkt_arbiter
    import tx_pkt_arbiter_pkg::*;
#(
    parameter int BYTES          = 1,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         req,
    input  logic [15:0]        req_len0,
    input  logic [15:0]        req_len1,
    input  logic [1:0]         req_bpsk,
    input  logic [BYTES*8-1:0] s0_tdata,
    input  logic               s0_tvalid,
    output logic               s0_tready,
    input  logic [BYTES*8-1:0] s1_tdata,
    input  logic               s1_tvalid,
    output logic               s1_tready,
    output logic [BYTES*8-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               m_tuser,
    output logic [15:0]        payload_length,
    input  logic               pkt_sent,
    output logic [1:0]         grant,
    output logic [1:0]         done,
    output logic               err,
    output logic               busy
);

    // Terminal values of the GAP and DRAIN counters.
    localparam len_t GAP_LAST = len_t'(GAP_CYCLES - 1);
    localparam len_t TO_LAST  = len_t'(TIMEOUT_CYCLES - 1);

    state_t       state;
    len_t         symbols;
    len_t         beat_cnt;
    len_t         wait_cnt;
    len_t         gap_cnt;
    logic         pkt_sent_q;
    logic         sent_seen;
    logic [1:0]   win;
    logic         in_xfer;
    logic         src_vld;
    logic         beat_last;
    logic         beat_fire;
    logic         pkt_edge;
    logic         sent_hit;
    logic         rr_upd;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .upd     (rr_upd),
        .upd_gnt (grant),
        .win     (win)
    );

    // ---------------------------------------------------------------
    // Datapath mux: only the granted source sees m_tready, and only in XFER.
    // ---------------------------------------------------------------
    assign in_xfer = (state == ST_XFER);

    always_comb begin
        src_vld = 1'b0;
        m_tdata = s0_tdata;
        if (grant[1]) begin
            src_vld = s1_tvalid;
            m_tdata = s1_tdata;
        end else if (grant[0]) begin
            src_vld = s0_tvalid;
        end
    end

    assign m_tvalid  = in_xfer & src_vld;
    assign s0_tready = in_xfer & grant[0] & m_tready;
    assign s1_tready = in_xfer & grant[1] & m_tready;
    assign beat_last = (beat_cnt == symbols - 16'd1);
    assign m_tlast   = in_xfer & beat_last;
    assign beat_fire = m_tvalid & m_tready;

    assign pkt_edge  = pkt_sent & ~pkt_sent_q;
    // The packetizer may report completion while the tail is still being
    // streamed, so an edge remembered since LOAD counts as well.
    assign sent_hit  = sent_seen | pkt_edge;
    assign rr_upd    = (state == ST_DRAIN) & sent_hit;
    assign busy      = (state != ST_IDLE);

    // ---------------------------------------------------------------
    // Scheduler FSM with registered outputs.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            grant          <= 2'b00;
            done           <= 2'b00;
            err            <= 1'b0;
            payload_length <= '0;
            m_tuser        <= 1'b0;
            symbols        <= '0;
            beat_cnt       <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            pkt_sent_q     <= 1'b0;
            sent_seen      <= 1'b0;
        end else begin
            done       <= 2'b00;
            err        <= 1'b0;
            pkt_sent_q <= pkt_sent;

            case (state)
                ST_IDLE: begin
                    if (enable && (req != 2'b00)) begin
                        grant <= win;
                        if (win[1]) begin
                            payload_length <= req_len1;
                            m_tuser        <= req_bpsk[1];
                            symbols        <= len_to_symbols(req_len1, req_bpsk[1]);
                        end else begin
                            payload_length <= req_len0;
                            m_tuser        <= req_bpsk[0];
                            symbols        <= len_to_symbols(req_len0, req_bpsk[0]);
                        end
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (symbols == '0) begin
                        // Nothing to send: reject without touching the RR priority.
                        err   <= 1'b1;
                        grant <= 2'b00;
                        state <= ST_IDLE;
                    end else begin
                        beat_cnt  <= '0;
                        wait_cnt  <= '0;
                        gap_cnt   <= '0;
                        sent_seen <= pkt_edge;
                        state     <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (pkt_edge) begin
                        sent_seen <= 1'b1;
                    end
                    if (beat_fire) begin
                        if (beat_last) begin
                            state <= ST_DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (sent_hit) begin
                        done  <= grant;
                        grant <= 2'b00;
                        state <= ST_GAP;
                    end else if (wait_cnt == TO_LAST) begin
                        // TIMEOUT_CYCLES DRAIN cycles without a pkt_sent edge.
                        err   <= 1'b1;
                        grant <= 2'b00;
                        state <= ST_GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                default: begin
                    grant <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tx_pkt_arbiter_tb_dummy_guard.sv


// File: tb/tb_tx_pkt_arbiter.sv
// Self-checking bench for tx_pkt_arbiter: randomized packets against a transaction-level model.
// Latency: checks grant latency, last-beat-to-done and last-beat-to-timeout distances.
// Backpressure: exercises constant, toggling and random m_tready plus random source valid.
module tb_tx_pkt_arbiter;

    localparam int GAP = 16;
    localparam int TO  = 4096;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  req;
    logic [15:0] req_len0;
    logic [15:0] req_len1;
    logic [1:0]  req_bpsk;
    logic [7:0]  s0_tdata;
    logic        s0_tvalid;
    logic        s0_tready;
    logic [7:0]  s1_tdata;
    logic        s1_tvalid;
    logic        s1_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] payload_length;
    logic        pkt_sent;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        err;
    logic        busy;

    tx_pkt_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .req            (req),
        .req_len0       (req_len0),
        .req_len1       (req_len1),
        .req_bpsk       (req_bpsk),
        .s0_tdata       (s0_tdata),
        .s0_tvalid      (s0_tvalid),
        .s0_tready      (s0_tready),
        .s1_tdata       (s1_tdata),
        .s1_tvalid      (s1_tvalid),
        .s1_tready      (s1_tready),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser),
        .payload_length (payload_length),
        .pkt_sent       (pkt_sent),
        .grant          (grant),
        .done           (done),
        .err            (err),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Source word queues, observed beats and event bookkeeping.
    logic [7:0] src0_q[$];
    logic [7:0] src1_q[$];
    logic [7:0] obs_dat[$];
    logic       obs_last[$];
    logic       obs_user[$];
    int         cyc = 0;
    int         last_cyc = 0;
    int         done_cyc = 0;
    int         err_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         xviol = 0;
    logic [1:0] done_or = 2'b00;
    int         sent_delay = -1;
    int         sent_timer = -1;
    int         sent_hi = 0;
    int         tready_mode = 0;
    bit         src_rand = 0;
    bit         hold0 = 0;
    bit         hold1 = 0;
    int         ref_prio = 0;   // model: channel favoured on a tie

    // Cycle driver and monitor: drive on the falling edge, sample 1 ns later.
    initial begin
        forever begin
            @(negedge clk);
            if (sent_hi > 0) begin
                sent_hi--;
                if (sent_hi == 0) pkt_sent = 1'b0;
            end
            if (sent_timer == 0) begin
                pkt_sent   = 1'b1;
                sent_hi    = 3;
                sent_timer = -1;
            end else if (sent_timer > 0) begin
                sent_timer--;
            end

            case (tready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase

            if (!hold0) begin
                if (src0_q.size() > 0 && (!src_rand || $urandom_range(0, 3) != 0)) begin
                    s0_tvalid = 1'b1;
                    s0_tdata  = src0_q[0];
                end else begin
                    s0_tvalid = 1'b0;
                end
            end
            if (!hold1) begin
                if (src1_q.size() > 0 && (!src_rand || $urandom_range(0, 3) != 0)) begin
                    s1_tvalid = 1'b1;
                    s1_tdata  = src1_q[0];
                end else begin
                    s1_tvalid = 1'b0;
                end
            end

            #1;
            cyc++;
            if (m_tvalid === 1'b1 && m_tready) begin
                obs_dat.push_back(m_tdata);
                obs_last.push_back(m_tlast);
                obs_user.push_back(m_tuser);
                if (m_tlast === 1'b1) begin
                    last_cyc = cyc;
                    if (sent_delay >= 0) sent_timer = sent_delay;
                end
            end
            hold0 = s0_tvalid && (s0_tready !== 1'b1);
            hold1 = s1_tvalid && (s1_tready !== 1'b1);
            if (s0_tvalid && s0_tready === 1'b1 && src0_q.size() > 0) void'(src0_q.pop_front());
            if (s1_tvalid && s1_tready === 1'b1 && src1_q.size() > 0) void'(src1_q.pop_front());
            if (!$isunknown(done) && done != 2'b00) begin
                done_or  = done_or | done;
                done_cnt++;
                done_cyc = cyc;
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if ((s0_tready === 1'b1 && grant[0] !== 1'b1) ||
                (s1_tready === 1'b1 && grant[1] !== 1'b1)) xviol++;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_mon();
        obs_dat.delete();
        obs_last.delete();
        obs_user.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        done_or    = 2'b00;
        xviol      = 0;
        sent_timer = -1;
    endtask

    // One request-to-idle transaction. Expected behaviour comes from the
    // packet-level rules: who wins, how many symbols, how it completes.
    task automatic do_pkt(input string nm, input logic [1:0] rq, input logic [15:0] l0,
                          input logic [15:0] l1, input logic [1:0] bp, input int dly,
                          input int tmode, input bit srand);
        int          w;
        logic [15:0] len;
        logic        bpk;
        int          sym;
        int          n;
        int          gap;
        bit          exp_done;
        logic [7:0]  exp_q[$];
        logic [7:0]  d;

        if (rq == 2'b11) w = ref_prio;
        else             w = rq[1] ? 1 : 0;
        len = (w == 1) ? l1 : l0;
        bpk = bp[w];
        sym = bpk ? int'(len) : int'(len) / 2;
        exp_done = (sym > 0) && (dly >= 0);

        for (int i = 0; i < sym; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            if (w == 1) src1_q.push_back(d);
            else        src0_q.push_back(d);
        end

        clear_mon();
        sent_delay  = dly;
        tready_mode = tmode;
        src_rand    = srand;
        req_len0    = l0;
        req_len1    = l1;
        req_bpsk    = bp;
        req         = rq;
        enable      = 1'b1;

        step();
        chk({nm, "_grant"}, {30'd0, grant}, (w == 1) ? 32'd2 : 32'd1);

        n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < 6000) begin
            step();
            n++;
        end
        req = 2'b00;
        chk({nm, "_ended"}, (n < 6000) ? 32'd1 : 32'd0, 32'd1);

        gap = 0;
        while (busy === 1'b1 && gap < 100) begin
            step();
            gap++;
        end
        chk({nm, "_gap"}, gap, (sym > 0) ? GAP : 0);

        chk({nm, "_done_cnt"}, done_cnt, exp_done ? 1 : 0);
        chk({nm, "_done"}, {30'd0, done_or}, exp_done ? ((w == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk({nm, "_err_cnt"}, err_cnt, exp_done ? 0 : 1);
        chk({nm, "_plen"}, {16'd0, payload_length}, {16'd0, len});
        chk({nm, "_tuser"}, {31'd0, m_tuser}, {31'd0, bpk});
        chk({nm, "_nbeats"}, obs_dat.size(), sym);
        chk({nm, "_xtready"}, xviol, 0);
        for (int i = 0; i < sym && i < obs_dat.size(); i++) begin
            chk({nm, "_data"}, {24'd0, obs_dat[i]}, {24'd0, exp_q[i]});
            chk({nm, "_last"}, {31'd0, obs_last[i]}, (i == sym - 1) ? 32'd1 : 32'd0);
            chk({nm, "_beat_user"}, {31'd0, obs_user[i]}, {31'd0, bpk});
        end
        if (sym > 0 && dly >= 0) chk({nm, "_done_lat"}, done_cyc - last_cyc, dly + 2);
        if (sym > 0 && dly < 0)  chk({nm, "_to_lat"}, err_cyc - last_cyc, TO + 1);

        if (exp_done) ref_prio = w ^ 1;
    endtask

    initial begin
        logic [1:0]  rq;
        logic [15:0] l0;
        logic [15:0] l1;

        rst_n     = 1'b0;
        enable    = 1'b1;
        req       = 2'b11;
        req_len0  = 16'd5;
        req_len1  = 16'd5;
        req_bpsk  = 2'b11;
        pkt_sent  = 1'b0;
        m_tready  = 1'b0;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        s0_tdata  = 8'h00;
        s1_tdata  = 8'h00;

        repeat (3) @(posedge clk);
        step();
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_tready", {30'd0, s1_tready, s0_tready}, 32'd0);
        chk("rst_plen", {16'd0, payload_length}, 32'd0);
        chk("rst_tuser", {31'd0, m_tuser}, 32'd0);
        chk("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
        req   = 2'b00;
        rst_n = 1'b1;
        step();

        // Directed packets.
        do_pkt("bpsk5",  2'b01, 16'd5, 16'd0, 2'b01, 3, 0, 0);
        do_pkt("qpsk8",  2'b10, 16'd0, 16'd8, 2'b00, 0, 0, 0);
        do_pkt("cont_a", 2'b11, 16'd6, 16'd10, 2'b01, 2, 0, 0);
        do_pkt("cont_b", 2'b11, 16'd6, 16'd10, 2'b01, 2, 0, 0);
        do_pkt("cont_c", 2'b11, 16'd6, 16'd10, 2'b01, 2, 0, 0);
        do_pkt("zero",   2'b01, 16'd1, 16'd0, 2'b00, 1, 0, 0);
        do_pkt("one",    2'b10, 16'd0, 16'd1, 2'b10, 1, 0, 0);
        do_pkt("tmo",    2'b01, 16'd4, 16'd0, 2'b01, -1, 1, 0);

        // enable low must hold off the grant.
        enable = 1'b0;
        req    = 2'b01;
        repeat (6) step();
        chk("en_grant", {30'd0, grant}, 32'd0);
        chk("en_busy", {31'd0, busy}, 32'd0);
        req    = 2'b00;
        enable = 1'b1;
        step();

        // Randomized packets with random backpressure and source stalls.
        for (int k = 0; k < 10; k++) begin
            rq = 2'($urandom_range(1, 3));
            l0 = 16'($urandom_range(0, 24));
            l1 = 16'($urandom_range(0, 24));
            do_pkt("rnd", rq, l0, l1, 2'($urandom_range(0, 3)), $urandom_range(0, 10), 2, 1);
        end

        // Reset in the middle of a transfer aborts silently.
        clear_mon();
        tready_mode = 0;
        src_rand    = 0;
        for (int i = 0; i < 20; i++) src0_q.push_back(8'($urandom));
        req_len0 = 16'd20;
        req_bpsk = 2'b01;
        req      = 2'b01;
        for (int n = 0; n < 50 && obs_dat.size() < 3; n++) step();
        req   = 2'b00;
        rst_n = 1'b0;
        repeat (2) step();
        chk("abort_beats", (obs_dat.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        chk("abort_done", done_cnt, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_grant", {30'd0, grant}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        src0_q.delete();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
